// File: rtl/basket_pkg.sv
// basket_pkg: shared widths, reset image, FSM state type and slot offset helper for the basket text scheduler.
package basket_pkg;
    localparam int NUM_SLOTS_C    = 12;
    localparam int CHARS_PER_SLOT = 9;
    localparam int CHAR_W         = 7;
    localparam int SLOT_W         = CHARS_PER_SLOT * CHAR_W;
    localparam int WORDS_W        = NUM_SLOTS_C * SLOT_W;
    localparam logic [CHAR_W-1:0] SPACE_CODE = 7'h20;
    localparam logic [WORDS_W-1:0] ALL_SPACE = {(WORDS_W / CHAR_W){SPACE_CODE}};

    typedef enum logic {IDLE, STAGED} sched_state_t;

    // Slot 0 sits at the top of the image, so the LSB of slot k is 693-63k.
    function automatic int slot_lsb(input logic [3:0] k);
        return WORDS_W - SLOT_W * (int'(k) + 1);
    endfunction
endpackage

// File: rtl/basket_text_scheduler_if.sv
// basket_text_scheduler_if: producer-side request/text bus, clear pulse, video line and text image.
interface basket_text_scheduler_if;
    import basket_pkg::*;
    logic [1:0]         REQ;
    logic [3:0]         SLOT0;
    logic [3:0]         SLOT1;
    logic [SLOT_W-1:0]  TEXT0;
    logic [SLOT_W-1:0]  TEXT1;
    logic               CLR;
    logic [9:0]         VE_COUNTER;
    logic [1:0]         GNT;
    logic               ERR;
    logic               BUSY;
    logic [WORDS_W-1:0] WORDS;

    modport master (output REQ, SLOT0, SLOT1, TEXT0, TEXT1, CLR, VE_COUNTER,
                    input GNT, ERR, BUSY, WORDS);
    modport slave  (input REQ, SLOT0, SLOT1, TEXT0, TEXT1, CLR, VE_COUNTER,
                    output GNT, ERR, BUSY, WORDS);
endinterface

// File: rtl/basket_text_scheduler_rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter; a tie goes to the requester not granted last.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output logic       last_o
);
    logic last_q;

    assign gnt_o  = !en_i ? 2'b00 : (&req_i) ? (last_q ? 2'b01 : 2'b10) : req_i;
    assign last_o = last_q;

    always_ff @(posedge clk) begin
        if (rst)
            last_q <= 1'b1;
        else if (|gnt_o)
            last_q <= gnt_o[1];
    end
endmodule

// File: rtl/basket_text_scheduler.sv
// basket_text_scheduler: arbitrates slot writes into the 756-bit text image and commits them in vertical blank.
// Define BASKET_BLANK_SYNC_EN to gate commits/clears by the blank window; otherwise the window is always open.
module basket_text_scheduler
    import basket_pkg::*;
#(
    parameter int         NUM_SLOTS   = NUM_SLOTS_C,
    parameter logic [9:0] BLANK_START = 10'd528,
    parameter logic [9:0] BLANK_END   = 10'd72
) (
    input logic CLK,
    input logic RESET,
    basket_text_scheduler_if.slave bus
);
`ifdef BASKET_BLANK_SYNC_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif
    localparam logic [3:0] LAST_SLOT = 4'(NUM_SLOTS - 1);

    sched_state_t       state_q;
    logic [1:0]         gnt, gnt_q;
    logic               err_q, bad_q, clr_pend_q, in_blank, win, sel_bad;
    logic [3:0]         slot_q, sel_slot;
    logic [SLOT_W-1:0]  text_q, sel_text;
    logic [WORDS_W-1:0] words_q;

    rr_arbiter2 u_arb (
        .clk    (CLK),
        .rst    (RESET),
        .req_i  (bus.REQ),
        .en_i   (state_q == IDLE),
        .gnt_o  (gnt),
        .last_o ()
    );

    assign in_blank = bus.VE_COUNTER >= BLANK_START || bus.VE_COUNTER < BLANK_END;
    assign win      = in_blank | !SYNC_EN;
    assign sel_slot = gnt[1] ? bus.SLOT1 : bus.SLOT0;
    assign sel_text = gnt[1] ? bus.TEXT1 : bus.TEXT0;
    assign sel_bad  = sel_slot > LAST_SLOT;

    // Clear is written first so a same-cycle staged commit overlays it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            gnt_q      <= 2'b00;
            err_q      <= 1'b0;
            bad_q      <= 1'b0;
            clr_pend_q <= 1'b0;
            slot_q     <= 4'd0;
            text_q     <= '0;
            words_q    <= ALL_SPACE;
        end else begin
            gnt_q      <= gnt;
            err_q      <= (|gnt) & sel_bad;
            clr_pend_q <= clr_pend_q ? !win : bus.CLR;
            if (clr_pend_q && win)
                words_q <= ALL_SPACE;
            if (state_q == IDLE && |gnt) begin
                state_q <= STAGED;
                slot_q  <= sel_slot;
                text_q  <= sel_text;
                bad_q   <= sel_bad;
            end
            if (state_q == STAGED && win) begin
                state_q <= IDLE;
                if (!bad_q)
                    words_q[slot_lsb(slot_q) +: SLOT_W] <= text_q;
            end
        end
    end

    assign bus.GNT   = gnt_q;
    assign bus.ERR   = err_q;
    assign bus.BUSY  = (state_q == STAGED);
    assign bus.WORDS = words_q;
endmodule

// File: tb/tb_basket_text_scheduler.sv
// tb_basket_text_scheduler: directed scenarios for grant, commit window, round robin, error, clear and reset.
module tb_basket_text_scheduler;
`ifdef BASKET_BLANK_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst;
    int n_vec = 0;
    int n_err = 0;
    logic [755:0] exp_w, old_w;

    basket_text_scheduler_if bus();

    basket_text_scheduler dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [62:0] pack9(input string s);
        logic [62:0] t;
        byte b;
        t = '0;
        for (int i = 0; i < 9; i++) begin
            b = s.getc(i);
            t[62-7*i -: 7] = b[6:0];
        end
        return t;
    endfunction

    function automatic logic [755:0] spaces();
        logic [755:0] w;
        for (int i = 0; i < 108; i++) w[7*i +: 7] = 7'h20;
        return w;
    endfunction

    function automatic logic [755:0] put(input logic [755:0] w, input int k, input logic [62:0] t);
        logic [755:0] r;
        r = w;
        r[755-63*k -: 63] = t;
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_w = spaces();
    endtask

    task automatic test_reset();
        bus.VE_COUNTER = 10'd300;
        do_reset();
        n_vec++; if (bus.WORDS !== exp_w) begin n_err++; $display("FAIL reset_words: got %h want %h", bus.WORDS, exp_w); end
        n_vec++; if (bus.GNT !== 2'b00) begin n_err++; $display("FAIL reset_gnt: got %b want 00", bus.GNT); end
        n_vec++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
        n_vec++; if (bus.ERR !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", bus.ERR); end
    endtask

    task automatic test_single();
        old_w = exp_w;
        exp_w = put(exp_w, 3, pack9("APPLE 4.5"));
        bus.VE_COUNTER = 10'd300;
        bus.SLOT0 = 4'd3;
        bus.TEXT0 = pack9("APPLE 4.5");
        bus.REQ = 2'b01;
        tick();
        n_vec++; if (bus.GNT !== 2'b01) begin n_err++; $display("FAIL single_gnt: got %b want 01", bus.GNT); end
        n_vec++; if (bus.BUSY !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", bus.BUSY); end
        bus.REQ = 2'b00;
        tick();
        n_vec++; if (bus.GNT !== 2'b00) begin n_err++; $display("FAIL single_gnt_drop: got %b want 00", bus.GNT); end
        n_vec++; if (bus.BUSY !== SYNC) begin n_err++; $display("FAIL single_busy_hold: got %b want %b", bus.BUSY, SYNC); end
        n_vec++; if (bus.WORDS !== (SYNC ? old_w : exp_w)) begin n_err++; $display("FAIL single_pre_window: got %h want %h", bus.WORDS, SYNC ? old_w : exp_w); end
        bus.VE_COUNTER = 10'd527;
        tick();
        n_vec++; if (bus.WORDS !== (SYNC ? old_w : exp_w)) begin n_err++; $display("FAIL single_line527: got %h want %h", bus.WORDS, SYNC ? old_w : exp_w); end
        bus.VE_COUNTER = 10'd528;
        tick();
        n_vec++; if (bus.WORDS[566:504] !== pack9("APPLE 4.5")) begin n_err++; $display("FAIL single_slot3: got %h want %h", bus.WORDS[566:504], pack9("APPLE 4.5")); end
        n_vec++; if (bus.WORDS !== exp_w) begin n_err++; $display("FAIL single_words: got %h want %h", bus.WORDS, exp_w); end
        n_vec++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL single_busy_fall: got %b want 0", bus.BUSY); end
    endtask

    task automatic test_boundary();
        old_w = exp_w;
        exp_w = put(exp_w, 5, pack9("BANANA 12"));
        bus.VE_COUNTER = 10'd72;
        bus.SLOT0 = 4'd5;
        bus.TEXT0 = pack9("BANANA 12");
        bus.REQ = 2'b01;
        tick();
        bus.REQ = 2'b00;
        tick();
        n_vec++; if (bus.WORDS !== (SYNC ? old_w : exp_w)) begin n_err++; $display("FAIL bound_line72: got %h want %h", bus.WORDS, SYNC ? old_w : exp_w); end
        bus.VE_COUNTER = 10'd71;
        tick();
        n_vec++; if (bus.WORDS !== exp_w) begin n_err++; $display("FAIL bound_line71: got %h want %h", bus.WORDS, exp_w); end
        n_vec++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL bound_busy: got %b want 0", bus.BUSY); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [3] = '{2'b01, 2'b10, 2'b01};
        bus.VE_COUNTER = 10'd528;
        do_reset();
        exp_w = put(exp_w, 1, pack9("KEYPAD  1"));
        exp_w = put(exp_w, 2, pack9("SALES   2"));
        bus.SLOT0 = 4'd1;
        bus.TEXT0 = pack9("KEYPAD  1");
        bus.SLOT1 = 4'd2;
        bus.TEXT1 = pack9("SALES   2");
        bus.REQ = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (bus.GNT !== seq[i]) begin n_err++; $display("FAIL rr_gnt%0d: got %b want %b", i, bus.GNT, seq[i]); end
            if (i == 2) bus.REQ = 2'b00;
            tick();
            n_vec++; if (bus.GNT !== 2'b00 || bus.BUSY !== 1'b0) begin n_err++; $display("FAIL rr_gap%0d: got gnt %b busy %b want 00 0", i, bus.GNT, bus.BUSY); end
        end
        n_vec++; if (bus.WORDS !== exp_w) begin n_err++; $display("FAIL rr_words: got %h want %h", bus.WORDS, exp_w); end
    endtask

    task automatic test_error();
        bus.VE_COUNTER = 10'd300;
        bus.SLOT1 = 4'd13;
        bus.TEXT1 = pack9("XXXXXXXXX");
        bus.REQ = 2'b10;
        tick();
        n_vec++; if (bus.GNT !== 2'b10 || bus.ERR !== 1'b1) begin n_err++; $display("FAIL err_pulse: got gnt %b err %b want 10 1", bus.GNT, bus.ERR); end
        bus.REQ = 2'b00;
        tick();
        n_vec++; if (bus.ERR !== 1'b0) begin n_err++; $display("FAIL err_drop: got %b want 0", bus.ERR); end
        bus.VE_COUNTER = 10'd528;
        tick();
        tick();
        n_vec++; if (bus.WORDS !== exp_w) begin n_err++; $display("FAIL err_words: got %h want %h", bus.WORDS, exp_w); end
        n_vec++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL err_busy: got %b want 0", bus.BUSY); end
    endtask

    task automatic test_clear();
        old_w = exp_w;
        exp_w = put(spaces(), 0, pack9("MILK   99"));
        bus.VE_COUNTER = 10'd200;
        bus.SLOT0 = 4'd0;
        bus.TEXT0 = pack9("MILK   99");
        bus.REQ = 2'b01;
        bus.CLR = 1'b1;
        tick();
        n_vec++; if (bus.GNT !== 2'b01) begin n_err++; $display("FAIL clr_gnt: got %b want 01", bus.GNT); end
        bus.REQ = 2'b00;
        bus.CLR = 1'b0;
        tick();
        n_vec++; if (bus.WORDS !== (SYNC ? old_w : exp_w)) begin n_err++; $display("FAIL clr_pre_window: got %h want %h", bus.WORDS, SYNC ? old_w : exp_w); end
        bus.VE_COUNTER = 10'd528;
        tick();
        n_vec++; if (bus.WORDS !== exp_w) begin n_err++; $display("FAIL clr_words: got %h want %h", bus.WORDS, exp_w); end
        tick();
        n_vec++; if (bus.WORDS !== exp_w) begin n_err++; $display("FAIL clr_stable: got %h want %h", bus.WORDS, exp_w); end
    endtask

    task automatic test_reset_mid();
        bus.VE_COUNTER = 10'd400;
        bus.SLOT1 = 4'd7;
        bus.TEXT1 = pack9("BREAD 2.0");
        bus.REQ = 2'b10;
        tick();
        n_vec++; if (bus.GNT !== 2'b10) begin n_err++; $display("FAIL rstmid_gnt: got %b want 10", bus.GNT); end
        bus.REQ = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_w = spaces();
        bus.VE_COUNTER = 10'd528;
        tick();
        tick();
        n_vec++; if (bus.WORDS !== exp_w) begin n_err++; $display("FAIL rstmid_words: got %h want %h", bus.WORDS, exp_w); end
        n_vec++; if (bus.BUSY !== 1'b0 || bus.GNT !== 2'b00) begin n_err++; $display("FAIL rstmid_busy: got busy %b gnt %b want 0 00", bus.BUSY, bus.GNT); end
    endtask

    initial begin
        rst = 1'b1;
        bus.REQ = 2'b00;
        bus.SLOT0 = 4'd0;
        bus.SLOT1 = 4'd0;
        bus.TEXT0 = '0;
        bus.TEXT1 = '0;
        bus.CLR = 1'b0;
        bus.VE_COUNTER = 10'd0;
        test_reset();
        test_single();
        test_boundary();
        test_back_to_back();
        test_error();
        test_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
